sm2c_serial_conv: RTL and testbench

- Multi-channel, bit-serial converter between sign-magnitude and two's-complement, selectable per transaction.
- Successor to the combinational two-input complement converter. Generalised to CHANNELS lanes and both conversion directions.
- Adds a valid/ready handshake, registered outputs, and negative-zero and overflow flags.
- Sits between the ALU operand stage and the datapath; trades BITNUMBER cycles of latency for one-bit-per-lane logic.

---
 rtl/sm2c_serial_conv.sv | 146 ++++++++++++++
 tb/tb_sm2c_serial_conv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm2c_serial_conv.sv
// Bit-serial, multi-lane converter between sign-magnitude and two's-complement.
// Every lane shares one FSM; magnitudes are processed LSB first, one bit per clock.
module sm2c_serial_conv #(
  parameter int BITNUMBER = 8,
  parameter int CHANNELS  = 2
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic [CHANNELS*BITNUMBER-1:0] din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*BITNUMBER-1:0] dout,
  output logic [CHANNELS-1:0]           nzero,
  output logic [CHANNELS-1:0]           ovf
);

  localparam int MW = BITNUMBER - 1;
  localparam int CW = $clog2(BITNUMBER);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          mode_q, mode_d;
  logic [CHANNELS-1:0]           sign_q, sign_d;
  logic [CHANNELS-1:0]           seen_q, seen_d;
  logic [CHANNELS*MW-1:0]        mag_q, mag_d;
  logic [CHANNELS*BITNUMBER-1:0] dout_q, dout_d;
  logic [CHANNELS-1:0]           nzero_q, nzero_d;
  logic [CHANNELS-1:0]           ovf_q, ovf_d;
  logic                          accept;
  logic                          last_bit;

  // One serial negation step: the processed bit leaves at the bottom of the
  // magnitude and its result enters at the top, so after MW steps the converted
  // magnitude sits in place. Returns {seen_next, mag_next}.
  function automatic logic [MW:0] step_lane(input logic sg, input logic seen,
                                            input logic [MW-1:0] mag);
    logic          b;
    logic          r;
    logic [MW:0]   tmp;
    b   = mag[0];
    r   = (sg && seen) ? ~b : b;
    tmp = {r, mag};
    return {seen | b, tmp[MW:1]};
  endfunction

  // Final sign fix-up with negative-zero clearing and most-negative saturation.
  // Returns {ovf, nzero, word}.
  function automatic logic [BITNUMBER+1:0] fix_lane(input logic md, input logic sg,
                                                    input logic seen,
                                                    input logic [MW-1:0] mag);
    logic [BITNUMBER+1:0] r;
    r = {2'b00, sg, mag};
    if (sg && !seen) begin
      if (!md) r = {2'b01, {BITNUMBER{1'b0}}};
      else     r = {2'b10, 1'b1, {MW{1'b1}}};
    end
    return r;
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_bit  = (cnt_q == CW'(BITNUMBER - 2));
  assign out_valid = (state_q == DONE);
  assign dout      = dout_q;
  assign nzero     = nzero_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    seen_d  = seen_q;
    mag_d   = mag_q;
    dout_d  = dout_q;
    nzero_d = nzero_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        for (int c = 0; c < CHANNELS; c++) begin
          {seen_d[c], mag_d[c*MW +: MW]} = step_lane(sign_q[c], seen_q[c], mag_q[c*MW +: MW]);
        end
        cnt_d = cnt_q + 1'b1;
        if (last_bit) state_d = FIX;
      end
      FIX: begin
        for (int c = 0; c < CHANNELS; c++) begin
          {ovf_d[c], nzero_d[c], dout_d[c*BITNUMBER +: BITNUMBER]} =
            fix_lane(mode_q, sign_q[c], seen_q[c], mag_q[c*MW +: MW]);
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new word may be taken in IDLE or in the same edge that retires DONE.
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      mode_d  = mode;
      seen_d  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sign_d[c]          = din[c*BITNUMBER + MW];
        mag_d[c*MW +: MW]  = din[c*BITNUMBER +: MW];
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      nzero_q <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      nzero_q <= nzero_d;
      ovf_q   <= ovf_d;
    end
  end

  // Working datapath needs no reset: it is always reloaded on accept.
  always_ff @(posedge clk1) begin
    mode_q <= mode_d;
    sign_q <= sign_d;
    seen_q <= seen_d;
    mag_q  <= mag_d;
  end

endmodule

// File: tb/tb_sm2c_serial_conv.sv
// Self-checking bench for sm2c_serial_conv: table vectors, hand-written corner
// sequences, and randomized transactions against an arithmetic reference model.
module tb_sm2c_serial_conv;

  localparam int BN = 8;
  localparam int CH = 2;
  localparam int W  = BN * CH;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mode = 1'b0;
  logic [W-1:0]  din = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  dout;
  logic [CH-1:0] nzero;
  logic [CH-1:0] ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk1 = ~clk1;

  sm2c_serial_conv #(.BITNUMBER(BN), .CHANNELS(CH)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .din(din), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .nzero(nzero), .ovf(ovf)
  );

  typedef struct {
    logic          md;
    logic [W-1:0]  d;
    logic [W-1:0]  ed;
    logic [CH-1:0] enz;
    logic [CH-1:0] eov;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Reference: value-level conversion using integer arithmetic per lane.
  function automatic void model(input logic md, input logic [W-1:0] d,
                                output logic [W-1:0] r, output logic [CH-1:0] nz,
                                output logic [CH-1:0] ov);
    int half;
    int full;
    half = 1 << (BN - 1);
    full = 1 << BN;
    r = '0; nz = '0; ov = '0;
    for (int c = 0; c < CH; c++) begin
      int v;
      int m;
      int res;
      v   = int'(d[c*BN +: BN]);
      m   = v % half;
      res = v;
      if (v >= half) begin
        if (m == 0) begin
          if (!md) begin res = 0; nz[c] = 1'b1; end
          else begin res = full - 1; ov[c] = 1'b1; end
        end else if (!md) begin
          res = full - m;
        end else begin
          res = half + (full - v);
        end
      end
      r[c*BN +: BN] = res[BN-1:0];
    end
  endfunction

  // Presents a word (optionally retiring the pending result on the same edge)
  // and returns #1 after the accepting edge.
  task automatic accept_word(input logic md, input logic [W-1:0] d, input logic with_retire);
    int g;
    g = 0;
    mode = md; din = d; in_valid = 1'b1;
    if (with_retire) out_ready = 1'b1;
    while (!in_ready && g < 20) begin
      @(negedge clk1);
      g++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk1);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = ~md;
    din = W'($urandom);
  endtask

  // Called just after the accepting edge; the result must appear exactly BN edges later.
  task automatic wait_result(input string nm, input logic [W-1:0] ed,
                             input logic [CH-1:0] enz, input logic [CH-1:0] eov);
    logic early;
    early = 1'b0;
    for (int k = 1; k < BN; k++) begin
      @(posedge clk1);
      @(negedge clk1);
      if (out_valid) early = 1'b1;
    end
    chk({nm, "_early_valid"}, early, 0);
    @(posedge clk1);
    @(negedge clk1);
    chk({nm, "_out_valid"}, out_valid, 1);
    chk({nm, "_dout"}, dout, ed);
    chk({nm, "_nzero"}, nzero, enz);
    chk({nm, "_ovf"}, ovf, eov);
    chk({nm, "_in_ready_stall"}, in_ready, 0);
  endtask

  task automatic retire(input string nm);
    out_ready = 1'b1;
    @(posedge clk1);
    #1 out_ready = 1'b0;
    @(negedge clk1);
    chk({nm, "_retired_valid"}, out_valid, 0);
    chk({nm, "_retired_ready"}, in_ready, 1);
  endtask

  function automatic logic [BN-1:0] pick_lane();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'h7F;
      3: return 8'hFF;
      default: return BN'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  ed;
    logic [W-1:0]  held;
    logic [CH-1:0] enz;
    logic [CH-1:0] eov;
    logic          chain;
    logic          md;
    logic [W-1:0]  d;
    logic          stable;
    logic          seen_valid;

    vecs[0] = '{1'b0, 16'h0585, 16'h05FB, 2'b00, 2'b00};
    vecs[1] = '{1'b0, 16'h80FF, 16'h0081, 2'b10, 2'b00};
    vecs[2] = '{1'b1, 16'h80FB, 16'hFF85, 2'b00, 2'b10};
    vecs[3] = '{1'b1, 16'h81FF, 16'hFF81, 2'b00, 2'b00};
    vecs[4] = '{1'b0, 16'h7F00, 16'h7F00, 2'b00, 2'b00};

    repeat (3) @(negedge clk1);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_nzero", nzero, 0);
    chk("reset_ovf", ovf, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk1);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    for (int i = 0; i < 5; i++) begin
      accept_word(vecs[i].md, vecs[i].d, 1'b0);
      wait_result($sformatf("vec%0d", i), vecs[i].ed, vecs[i].enz, vecs[i].eov);
      retire($sformatf("vec%0d", i));
    end

    // Back-pressure, then same-edge retire and accept.
    accept_word(1'b1, 16'h80FB, 1'b0);
    wait_result("bp", 16'hFF85, 2'b00, 2'b10);
    held = dout;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk1);
      if (dout !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    chk("bp_hold_stable", stable, 1);
    accept_word(1'b1, 16'h7F01, 1'b1);
    wait_result("chain", 16'h7F01, 2'b00, 2'b00);
    retire("chain");

    // Reset in the middle of RUN aborts the word.
    accept_word(1'b0, 16'h1234, 1'b0);
    repeat (3) @(posedge clk1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_dout", dout, 0);
    @(negedge clk1);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk1);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_output", seen_valid, 0);
    accept_word(1'b0, 16'h8100, 1'b0);
    wait_result("after_abort", 16'hFF00, 2'b00, 2'b00);
    retire("after_abort");

    // Randomized transactions against the reference model.
    chain = 1'b0;
    for (int i = 0; i < 40; i++) begin
      md = $urandom_range(0, 1);
      d  = {pick_lane(), pick_lane()};
      model(md, d, ed, enz, eov);
      accept_word(md, d, chain);
      wait_result($sformatf("rnd%0d", i), ed, enz, eov);
      held = dout;
      stable = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk1);
        if (dout !== held || out_valid !== 1'b1) stable = 1'b0;
      end
      chk($sformatf("rnd%0d_hold", i), stable, 1);
      chain = $urandom_range(0, 1);
      if (!chain) retire($sformatf("rnd%0d", i));
    end
    if (chain) retire("rnd_last");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
